logic_serial_v2: RTL and testbench



---
 rtl/logic_serial_v2_if.sv | 34 +++
 rtl/logic_serial_v2.sv | 141 ++++++++++++++
 tb/tb_logic_serial_v2.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/logic_serial_v2_if.sv
// Handshake/bus bundle for logic_serial_v2: start request, operands, op and result.
// Carries the zero flag only when LOGIC_SERIAL_ZFLAG_EN is defined.
interface logic_serial_v2_if #(
  parameter int size = 8
);
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      op;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic [size-1:0] c;
  logic            c_valid;
  logic            c_ready;
  logic            busy;
`ifdef LOGIC_SERIAL_ZFLAG_EN
  logic            zero;
`endif

  modport master (
    output start_valid, op, a, b, c_ready,
    input  start_ready, c, c_valid, busy
`ifdef LOGIC_SERIAL_ZFLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  start_valid, op, a, b, c_ready,
    output start_ready, c, c_valid, busy
`ifdef LOGIC_SERIAL_ZFLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/logic_serial_v2.sv
// Bit-serial OR/AND/XOR/NOR unit: one bit per clock, LSB first, parallel result handshake.
// Optional zero-result flag enabled by defining LOGIC_SERIAL_ZFLAG_EN.
module logic_serial_v2 #(
  parameter int size = 8
) (
  input logic            clk,
  input logic            rst,
  logic_serial_v2_if.slave bus
);
  localparam int cw = $clog2(size + 1);
  localparam logic [cw-1:0] last_cnt = cw'(size - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t          state;
  op_t             op_r;
  logic [size-1:0] a_sh;
  logic [size-1:0] b_sh;
  logic [size-1:0] c_r;
  logic [cw-1:0]   cnt;
  logic            start_ready_r;
  logic            c_valid_r;
  logic            busy_r;

  logic            r;
  logic [size-1:0] c_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    r = 1'b0;
    unique case (op_r)
      OP_OR:   r = a_sh[0] | b_sh[0];
      OP_AND:  r = a_sh[0] & b_sh[0];
      OP_XOR:  r = a_sh[0] ^ b_sh[0];
      OP_NOR:  r = ~(a_sh[0] | b_sh[0]);
      default: r = 1'b0;
    endcase
    // Result fills from the MSB end so bit 0 lands in c[0] after size shifts.
    c_next         = c_r >> 1;
    c_next[size-1] = r;
  end

`ifdef LOGIC_SERIAL_ZFLAG_EN
  logic acc_or;
  logic zero_r;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand shift registers are plain flops, not a memory, and
      // their reset value is observable behaviour, so they are reset too.
      state         <= IDLE;
      op_r          <= OP_OR;
      a_sh          <= '0;
      b_sh          <= '0;
      c_r           <= '0;
      cnt           <= '0;
      start_ready_r <= 1'b1;
      c_valid_r     <= 1'b0;
      busy_r        <= 1'b0;
`ifdef LOGIC_SERIAL_ZFLAG_EN
      acc_or        <= 1'b0;
      zero_r        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid && start_ready_r) begin
            op_r          <= op_t'(bus.op);
            a_sh          <= bus.a;
            b_sh          <= bus.b;
            cnt           <= '0;
            state         <= SHIFT;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
`ifdef LOGIC_SERIAL_ZFLAG_EN
            acc_or        <= 1'b0;
            zero_r        <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          c_r  <= c_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
`ifdef LOGIC_SERIAL_ZFLAG_EN
          acc_or <= acc_or | r;
`endif
          if (cnt == last_cnt) begin
            state     <= DONE;
            c_valid_r <= 1'b1;
`ifdef LOGIC_SERIAL_ZFLAG_EN
            zero_r    <= ~(acc_or | r);
`endif
          end
        end

        DONE: begin
          if (bus.c_ready) begin
            state         <= IDLE;
            c_valid_r     <= 1'b0;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          start_ready_r <= 1'b1;
          c_valid_r     <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.c           = c_r;
  assign bus.c_valid     = c_valid_r;
  assign bus.busy        = busy_r;
`ifdef LOGIC_SERIAL_ZFLAG_EN
  assign bus.zero        = zero_r;
`endif

endmodule

// File: tb/tb_logic_serial_v2.sv
// Directed self-checking bench for logic_serial_v2 (size=8).
// Zero-flag vectors run only when LOGIC_SERIAL_ZFLAG_EN is defined.
module tb_logic_serial_v2;
  localparam int size = 8;
  localparam int max_wait = 50;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic_serial_v2_if #(.size(size)) bus ();

  logic_serial_v2 #(.size(size)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, checks acceptance, then waits for c_valid and returns the latency.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input string tag, output int lat);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start_valid = 1'b1;
    tick();
    check({tag, "_accept_ready"}, 32'(bus.start_ready), 32'd0);
    check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.c_valid && lat < max_wait) begin
      tick();
      lat++;
    end
    if (lat >= max_wait) check({tag, "_timeout"}, 32'(lat), 32'(size));
  endtask

  // Full transaction with c_ready held high; checks latency, result and handoff.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string tag);
    int lat;
    bus.c_ready = 1'b1;
    issue(op, a, b, tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(size));
    check({tag, "_c"}, 32'(bus.c), 32'(exp));
    tick();
    check({tag, "_handoff_valid"}, 32'(bus.c_valid), 32'd0);
    check({tag, "_handoff_ready"}, 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.c_ready = 1'b0;

    // Reset state
    #12;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_c_valid", 32'(bus.c_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_c", 32'(bus.c), 32'd0);
`ifdef LOGIC_SERIAL_ZFLAG_EN
    check("rst_zero", 32'(bus.zero), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Four ops on the same operands
    run_op(2'b00, 8'hA5, 8'h0F, 8'hAF, "or");
    run_op(2'b01, 8'hA5, 8'h0F, 8'h05, "and");
    run_op(2'b10, 8'hA5, 8'h0F, 8'hAA, "xor");
    run_op(2'b11, 8'hA5, 8'h0F, 8'h50, "nor");
    check("idle_c_keeps", 32'(bus.c), 32'h50);

    // Back-pressure: result must hold for 5 cycles of c_ready=0
    bus.c_ready = 1'b0;
    issue(2'b00, 8'h3C, 8'hC3, "bp", lat);
    check("bp_latency", 32'(lat), 32'(size));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_c", 32'(bus.c), 32'hFF);
      check("bp_hold_valid", 32'(bus.c_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.start_ready), 32'd0);
      tick();
    end
    bus.c_ready = 1'b1;
    tick();
    check("bp_handoff_valid", 32'(bus.c_valid), 32'd0);
    check("bp_handoff_ready", 32'(bus.start_ready), 32'd1);
    check("bp_handoff_busy", 32'(bus.busy), 32'd0);

    // Input change during SHIFT with start_valid left high
    bus.c_ready = 1'b0;
    bus.op = 2'b00;
    bus.a = 8'h01;
    bus.b = 8'h00;
    bus.start_valid = 1'b1;
    tick();
    check("chg_accept_ready", 32'(bus.start_ready), 32'd0);
    bus.op = 2'b01;
    bus.a = 8'hFF;
    lat = 0;
    while (!bus.c_valid && lat < max_wait) begin
      tick();
      lat++;
    end
    check("chg_latency", 32'(lat), 32'(size));
    check("chg_c", 32'(bus.c), 32'h01);
    bus.c_ready = 1'b1;
    tick();
    check("chg_handoff_ready", 32'(bus.start_ready), 32'd1);
    check("chg_handoff_busy", 32'(bus.busy), 32'd0);
    tick();
    check("chg_second_accept", 32'(bus.busy), 32'd1);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.c_valid && lat < max_wait) begin
      tick();
      lat++;
    end
    check("chg_second_c", 32'(bus.c), 32'h00);
    tick();

    // Asynchronous reset at bit 4, observed before any clock edge
    bus.op = 2'b10;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ar_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_c", 32'(bus.c), 32'd0);
    check("ar_c_valid", 32'(bus.c_valid), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_start_ready", 32'(bus.start_ready), 32'd1);
    #3;
    rst = 1'b0;
    tick();
    run_op(2'b10, 8'hF0, 8'h0F, 8'hFF, "ar_xor");

`ifdef LOGIC_SERIAL_ZFLAG_EN
    run_op(2'b00, 8'h00, 8'h00, 8'h00, "z_or0");
    check("z_or0_zero_idle", 32'(bus.zero), 32'd1);
    bus.c_ready = 1'b0;
    issue(2'b10, 8'h5A, 8'h5A, "z_xor", lat);
    check("z_xor_zero", 32'(bus.zero), 32'd1);
    bus.c_ready = 1'b1;
    tick();
    bus.c_ready = 1'b0;
    issue(2'b00, 8'h80, 8'h00, "z_or80", lat);
    check("z_or80_c", 32'(bus.c), 32'h80);
    check("z_or80_zero", 32'(bus.zero), 32'd0);
    bus.c_ready = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
